// File: rtl/mult32_pkg.sv
// mult32_pkg: shared state encoding and sizing for the sequential multiplier
package mult32_pkg;
    localparam int WIDTH_DEFAULT = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/mult32_seq_add33.sv
// add33: WIDTH+1-bit accumulator adder, carry kept for the shift step
module add33 #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum,
    output logic         carry
);
    assign {carry, sum} = {1'b0, x} + {1'b0, y};
endmodule

// File: rtl/mult32_seq.sv
// mult32_seq: shift-add multiplier, one bit per cycle; MULT32_SIGNED_EN adds two's complement operands
module mult32_seq
    import mult32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand, mplier, acc_hi, sum;
    logic               carry, ovf;
    logic [2*WIDTH-1:0] prod, fin;
`ifdef MULT32_SIGNED_EN
    logic               sign;
`endif

    add33 #(.W(WIDTH)) u_add (
        .x(acc_hi),
        .y(mplier[0] ? mcand : '0),
        .sum(sum),
        .carry(carry)
    );

    assign busy = state != IDLE;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next state: IDLE waits for start, RUN counts WIDTH iterations, DONE lasts one cycle
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (start ? RUN : IDLE)
                : state == RUN  ? (cnt == CNT_W'(WIDTH - 1) ? DONE : RUN)
                : IDLE;
    end

    // final product, sign correction and overflow test on the full double-width value
    always_comb begin
        prod = {acc_hi, mplier};
`ifdef MULT32_SIGNED_EN
        fin = sign ? -prod : prod;
        ovf = fin[2*WIDTH-1:WIDTH] != {WIDTH{fin[WIDTH-1]}};
`else
        fin = prod;
        ovf = |fin[2*WIDTH-1:WIDTH];
`endif
    end

    // datapath: latch operands, shift-add iterations, publish result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc_hi   <= '0;
            done     <= 1'b0;
            valid    <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
`ifdef MULT32_SIGNED_EN
            sign     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
`ifdef MULT32_SIGNED_EN
                mcand  <= a[WIDTH-1] ? -a : a;
                mplier <= b[WIDTH-1] ? -b : b;
                sign   <= a[WIDTH-1] ^ b[WIDTH-1];
`else
                mcand  <= a;
                mplier <= b;
`endif
                acc_hi <= '0;
                cnt    <= '0;
                valid  <= 1'b0;
            end else if (state == RUN) begin
                acc_hi <= {carry, sum[WIDTH-1:1]};
                mplier <= {sum[0], mplier[WIDTH-1:1]};
                cnt    <= cnt + CNT_W'(1);
            end else if (state == DONE) begin
                result   <= fin[WIDTH-1:0];
                overflow <= ovf;
                done     <= 1'b1;
                valid    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mult32_seq.sv
// tb_mult32_seq: randomized scoreboard bench for mult32_seq (honours MULT32_SIGNED_EN)
module tb_mult32_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, valid, overflow;
    logic [31:0] result;

    typedef struct {
        logic [31:0] r;
        logic        o;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    mult32_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .valid(valid), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] x, input logic [31:0] y, input int acc);
        exp_t e;
        logic [63:0] p;
`ifdef MULT32_SIGNED_EN
        p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        e.o = p[63:32] != {32{p[31]}};
`else
        p = {32'b0, x} * {32'b0, y};
        e.o = |p[63:32];
`endif
        e.r = p[31:0];
        e.acc = acc;
        return e;
    endfunction

    // monitor: every done pulse must match the oldest outstanding operation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.r);
                    chk("overflow", overflow, e.o);
                    chk("valid_at_done", valid, 1);
                    chk("latency", cyc - e.acc, 33);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit push);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("issue_wait_idle", busy, 0);
        a = x;
        b = y;
        start = 1'b1;
        if (push) q.push_back(mk(x, y, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic scramble(input int n);
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            b = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y;
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_valid", valid, 0);
        chk("reset_result", result, 0);
        chk("reset_overflow", overflow, 0);

        issue(32'd7, 32'd9, 1);
        issue(32'h0001_0000, 32'h0001_0000, 1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(32'hFFFF_FFFD, 32'd5, 1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(32'h8000_0000, 32'd1, 1);
        issue(32'd0, 32'hFFFF_FFFF, 1);
        drain();

        issue(32'd3, 32'd5, 1);
        repeat (3) @(negedge clk);
        a = 32'd100;
        b = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        issue(32'h1234_5678, 32'h0000_9ABC, 1);
        x = $urandom;
        y = $urandom;
        a = x;
        b = y;
        start = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", done, 1);
        q.push_back(mk(x, y, cyc + 1));
        @(posedge clk);
        #1;
        chk("b2b_valid_drop", valid, 0);
        chk("b2b_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        drain();

        for (int i = 0; i < 4; i++) begin
            issue($urandom, $urandom, 1);
            scramble(36);
        end
        drain();

        issue(32'd7, 32'd9, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_overflow", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        chk("midrst_valid_after", valid, 0);

        for (int i = 0; i < 25; i++) begin
            case (i % 4)
                0: issue($urandom, $urandom, 1);
                1: issue($urandom & 32'h0000_FFFF, $urandom & 32'h0000_FFFF, 1);
                2: issue($urandom | 32'h8000_0000, $urandom, 1);
                default: issue($urandom_range(0, 3), $urandom, 1);
            endcase
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult32_seq.md
Name: mult32_seq

Overview:
- Multi-cycle shift-add multiplier in the ALU datapath.
- Its 32-bit product feeds the `in1` leg of the ALU 32-bit 2:1 result mux. Its `done`/`valid` output drives that mux's `sel` path via the ALU control.
- One operand pair is accepted per operation; result is held stable until the next accepted start.

Parameters:
- WIDTH, 32, operand and result word width (the design is verified only at 32).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when the result becomes valid.
- valid  output  1  high from done until the next accepted start; low after reset.
- result  output  WIDTH  low WIDTH bits of the product.
- overflow  output  1  product does not fit in WIDTH bits.

Behaviour:
- Reset: asynchronous assert on rst_n low, synchronous-style release. On reset:
  - state=IDLE
  - busy=0, done=0, valid=0, result=0, overflow=0
  - counter=0, internal accumulator/multiplier/multiplicand registers=0
- States:
  - IDLE: start=1 -> latch a, b; clear accumulator; counter=0; go to RUN.
  - RUN: one iteration per cycle.
    - If multiplier LSB=1, add multiplicand into the accumulator high half, WIDTH+1-bit add with carry kept.
    - Shift {carry, acc_hi, multiplier} right by 1; counter++.
    - When counter reaches WIDTH-1 on this cycle, go to DONE.
  - DONE: load result=acc_lo and overflow, pulse done=1, set valid=1, go to IDLE.
- Latency: start sampled high at edge N -> done high in the cycle after edge N+WIDTH+1 (34 cycles total for WIDTH=32).
- busy=1 in RUN and DONE, 0 in IDLE.
- start while busy: ignored, no queueing; operands are not re-latched.
- start held high continuously: a new operation is accepted on the first IDLE cycle after each DONE. Back-to-back throughput is 1 op per WIDTH+2 cycles.
- valid drops to 0 on the edge a new start is accepted. result/overflow keep their old values until the next DONE.
- Operand changes on a/b after acceptance have no effect.
- Unsigned overflow: high WIDTH bits of the 2*WIDTH product are non-zero.
- Arithmetic: the full 2*WIDTH product is formed internally; nothing is truncated before the overflow check.
- Reset asserted mid-RUN: operation abandoned, all outputs return to reset values; no done pulse.

Optional Feature:
- Macro: MULT32_SIGNED_EN.
- Defined:
  - a and b are two's complement.
  - Operands are converted to magnitude at latch time, and the sign is recorded as sign_a XOR sign_b.
  - The 2*WIDTH product is negated in DONE if the sign bit is set.
  - overflow=1 when the high WIDTH bits are not all equal to result[WIDTH-1].
  - Special case: -2^31 * 1 gives result 0x80000000 with overflow=0.
  - Latency unchanged.
- Undefined: unsigned only, as described above; no sign logic is synthesised.

Decomposition:
- Package mult32_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoded
  - WIDTH_DEFAULT=32
  - CNT_W derivation
- One natural sub-module: add33, a WIDTH+1-bit adder producing sum and carry for the accumulator step.
- Control FSM and shift registers stay in mult32_seq.

Test Plan:
- Reset mid-operation: start a=7,b=9; assert rst_n=0 at cycle 10 -> busy=0, done=0, valid=0, result=0 immediately; no done pulse afterwards.
- Basic unsigned: a=0x0000_0007, b=0x0000_0009 -> done pulse exactly 34 cycles after start; result=0x0000_003F, overflow=0, valid=1.
- Overflow: a=0x0001_0000, b=0x0001_0000 -> result=0x0000_0000, overflow=1. Also a=0xFFFF_FFFF, b=0xFFFF_FFFF -> result=0x0000_0001, overflow=1.
- Busy handling: pulse start with a=3,b=5, then start with a=100,b=100 at cycle 5 -> ignored; result=15. A start on the cycle after done is accepted, and valid drops that edge.
- Operand hold: change a/b every cycle during RUN -> result equals the product of the values present at acceptance.
- Signed (MULT32_SIGNED_EN):
  - a=0xFFFF_FFFD (-3), b=5 -> result=0xFFFF_FFF1, overflow=0.
  - a=0x8000_0000, b=0xFFFF_FFFF -> result=0x8000_0000, overflow=1.
